pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage core. Generates write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects from the MEM stage, and multi-cycle data-memory accesses. A wait-state machine with a timeout detects a hung memory, and a saturating counter reports total stall cycles.

## Interface
Parameters:
- MAX_WAIT, 16, maximum consecutive memory wait cycles before error (2..255)
- PC_W, 14, jump-target / PC width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of instruction in EX
- ex_memread  in  1  EX instruction is a load
- mem_branch_taken  in  1  Branch&Zero of instruction in MEM
- mem_addr_jump  in  PC_W  branch target from EX/MEM
- mem_req  in  1  MEM instruction reads or writes data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all-zero controls)
- pc_sel  out  1  1 = next PC is pc_target
- pc_target  out  PC_W  redirect address
- mem_err  out  1  sticky memory-timeout flag
- stall_cycles  out  32  saturating count of cycles with pc_we=0

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Encoded in the package.
- Freeze condition F: mem_req & ~mem_ready, in RUN or MEM_WAIT.
  - Under F: pc/ifid/idex/exmem we=0, memwb_we=1, memwb_flush=1.
  - Branch and load-use handling are suppressed under F.
- RUN -> MEM_WAIT on F. MEM_WAIT stays while F; wait_cnt increments each MEM_WAIT cycle.
- MEM_WAIT -> RUN when mem_ready=1 or mem_req=0. That cycle is a normal (non-frozen) cycle. wait_cnt clears.
- MEM_WAIT -> ERR when F holds and wait_cnt == MAX_WAIT-1.
- ERR: mem_err=1, all we=0, all flush=0, pc_sel=0. Exit only by reset.
- Branch redirect, not frozen, mem_branch_taken=1:
  - pc_sel=1, pc_target=mem_addr_jump.
  - ifid_flush, idex_flush, exmem_flush=1; all we=1.
  - Load-use is ignored that cycle.
- Load-use, not frozen, no branch:
  - Condition: ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | id_uses_rs2 & ex_rd==id_rs2).
  - Response: pc_we=0, ifid_we=0, idex_flush=1; exmem and memwb advance.
- Otherwise: all we=1, all flush=0, pc_sel=0, pc_target=0.
- stall_cycles increments every cycle pc_we=0 outside ERR; saturates at 0xFFFF_FFFF.
- Priority: reset > ERR > freeze > branch > load-use > normal.

## Timing
- Control outputs are combinational from inputs and current state; state, wait_cnt, mem_err and stall_cycles are registered.
- Reset (rst_n=0 at a clock edge): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
- While rst_n=0: all we=0, all flush=1, pc_sel=0, pc_target=0.
- Reset mid-wait returns to RUN on that edge regardless of mem_req.
- A load-use stall lasts exactly one cycle: the load moves to MEM and the condition clears.
- Branch redirect takes effect at the same edge; the three younger instructions become bubbles.
- mem_ready=1 on the first mem_req cycle means zero stall cycles.
- F for N cycles with N < MAX_WAIT gives N frozen cycles.
- ERR is entered at the edge ending the MAX_WAIT-th consecutive frozen cycle.
- mem_branch_taken with F: the branch is held frozen in MEM and redirects on the completion cycle.

## Structure
- pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, ERR}
  - REG_W=5, default PC_W, MAX_WAIT default
  - ctrl bundle struct: we/flush per stage
- Sub-module load_use_detect (combinational compare, x0 exclusion), instanced once.
- FSM, wait counter and stall counter live in the top.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle with pc_we=ifid_we=0, idex_flush=1; next cycle normal. stall_cycles=1.
- x0: ex_rd=0, id_rs1=0, ex_memread=1 -> no stall.
- Branch: mem_branch_taken=1, mem_addr_jump=0x0123, concurrent load-use -> pc_sel=1, pc_target=0x0123, ifid/idex/exmem_flush=1, pc_we=1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> 3 frozen cycles with memwb_flush=1, 4th cycle normal. stall_cycles=3, state back to RUN.
- Timeout: MAX_WAIT=4, mem_req=1, mem_ready=0 held -> ERR after 4th cycle, mem_err=1, all we=0. rst_n=0 for one cycle -> RUN, mem_err=0.
- Reset mid-wait: rst_n=0 in 2nd MEM_WAIT cycle -> all flush=1 during reset, state=RUN and counters 0 afterwards.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W        = 5;
  localparam int PC_W_DEF     = 14;
  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN  = ctrl_t'(9'b11111_0000);
  localparam ctrl_t CTRL_RST  = ctrl_t'(9'b00000_1111);
  localparam ctrl_t CTRL_FRZ  = ctrl_t'(9'b00001_0001);
  localparam ctrl_t CTRL_BR   = ctrl_t'(9'b11111_1110);
  localparam ctrl_t CTRL_LU   = ctrl_t'(9'b00111_0100);
  localparam ctrl_t CTRL_NONE = ctrl_t'(9'b00000_0000);
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that needs the result of a load in EX
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  output logic             hazard
);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard = ex_memread & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enables/flushes for load-use, branch redirect and memory wait
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int PC_W     = PC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             mem_branch_taken,
  input  logic [PC_W-1:0]  mem_addr_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_target,
  output logic             mem_err,
  output logic [31:0]      stall_cycles
);
  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_err_q;
  logic [31:0] stall_q;
  logic        lu, frz;
  ctrl_t       c;

  load_use_detect u_lu (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .hazard      (lu)
  );

  assign frz = mem_req & ~mem_ready & (state_q != ERR);

  always_comb begin
    c         = CTRL_RUN;
    pc_sel    = 1'b0;
    pc_target = '0;
    if (!rst_n) c = CTRL_RST;
    else if (state_q == ERR) c = CTRL_NONE;
    else if (frz) c = CTRL_FRZ;
    else if (mem_branch_taken) begin
      c         = CTRL_BR;
      pc_sel    = 1'b1;
      pc_target = mem_addr_jump;
    end
    else if (lu) c = CTRL_LU;
  end

  // wait_q counts consecutive frozen cycles, including the first one taken in RUN
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (state_q != ERR) begin
      wait_d  = frz ? wait_q + 8'd1 : 8'd0;
      state_d = !frz ? RUN :
                (state_q == MEM_WAIT && wait_q == 8'(MAX_WAIT - 1)) ? ERR : MEM_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_q | (state_d == ERR);
      if (state_q != ERR && !c.pc_we && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
          ifid_flush, idex_flush, exmem_flush, memwb_flush} = c;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard, branch, memory-wait and timeout behaviour
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [8:0] E_NORM = 9'b11111_0000;
  localparam logic [8:0] E_RST  = 9'b00000_1111;
  localparam logic [8:0] E_FRZ  = 9'b00001_0001;
  localparam logic [8:0] E_BR   = 9'b11111_1110;
  localparam logic [8:0] E_LU   = 9'b00111_0100;
  localparam logic [8:0] E_ERR  = 9'b00000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs2, ex_memread, mem_branch_taken, mem_req, mem_ready;
  logic [13:0] mem_addr_jump;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        pc_sel, mem_err;
  logic [13:0] pc_target;
  logic [31:0] stall_cycles;
  logic [8:0]  ctl;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(4), .PC_W(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_branch_taken(mem_branch_taken), .mem_addr_jump(mem_addr_jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .pc_sel(pc_sel), .pc_target(pc_target), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  assign ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_rd = '0;
    ex_memread = 1'b0; mem_branch_taken = 1'b0; mem_addr_jump = '0;
    mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(E_RST));
    chk("rst_pcsel", 32'(pc_sel), 32'd0);
    cyc(); cyc();
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1; #1;
    chk("norm_ctl", 32'(ctl), 32'(E_NORM));
    chk("norm_target", 32'(pc_target), 32'd0);

    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    chk("x0_ctl", 32'(ctl), 32'(E_NORM));

    ex_rd = 5'd5; id_rs1 = 5'd5; #1;
    chk("lu_ctl", 32'(ctl), 32'(E_LU));
    cyc();
    ex_memread = 1'b0; #1;
    chk("lu_after", 32'(ctl), 32'(E_NORM));
    chk("lu_stall", stall_cycles, 32'd1);

    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd7; id_uses_rs2 = 1'b0; #1;
    chk("rs2_unused", 32'(ctl), 32'(E_NORM));
    id_uses_rs2 = 1'b1; #1;
    chk("rs2_used", 32'(ctl), 32'(E_LU));
    cyc();
    ex_memread = 1'b0; #1;
    chk("rs2_stall", stall_cycles, 32'd2);

    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    mem_branch_taken = 1'b1; mem_addr_jump = 14'h0123; #1;
    chk("br_ctl", 32'(ctl), 32'(E_BR));
    chk("br_sel", 32'(pc_sel), 32'd1);
    chk("br_target", 32'(pc_target), 32'h0123);
    cyc();
    ex_memread = 1'b0; mem_branch_taken = 1'b0; #1;
    chk("br_stall", stall_cycles, 32'd2);

    mem_req = 1'b1; mem_ready = 1'b0; mem_branch_taken = 1'b1; mem_addr_jump = 14'h0ABC; #1;
    chk("wait1_ctl", 32'(ctl), 32'(E_FRZ));
    chk("wait1_sel", 32'(pc_sel), 32'd0);
    cyc();
    chk("wait2_state", 32'(dut.state_q), 32'(MEM_WAIT));
    chk("wait2_ctl", 32'(ctl), 32'(E_FRZ));
    cyc();
    chk("wait3_ctl", 32'(ctl), 32'(E_FRZ));
    cyc();
    mem_ready = 1'b1; #1;
    chk("wait_done_ctl", 32'(ctl), 32'(E_BR));
    chk("wait_done_target", 32'(pc_target), 32'h0ABC);
    cyc();
    mem_req = 1'b0; mem_ready = 1'b0; mem_branch_taken = 1'b0; #1;
    chk("wait_state", 32'(dut.state_q), 32'(RUN));
    chk("wait_stall", stall_cycles, 32'd5);

    mem_req = 1'b1; mem_ready = 1'b1; #1;
    chk("zero_wait_ctl", 32'(ctl), 32'(E_NORM));
    cyc();
    chk("zero_wait_state", 32'(dut.state_q), 32'(RUN));
    chk("zero_wait_stall", stall_cycles, 32'd5);

    mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_frz", 32'(ctl), 32'(E_FRZ));
      chk("to_noerr", 32'(mem_err), 32'd0);
      cyc();
    end
    chk("to_state", 32'(dut.state_q), 32'(ERR));
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_ctl", 32'(ctl), 32'(E_ERR));
    chk("to_stall", stall_cycles, 32'd9);
    cyc();
    chk("err_sticky", 32'(mem_err), 32'd1);
    chk("err_stall_hold", stall_cycles, 32'd9);
    rst_n = 1'b0; #1;
    chk("err_rst_ctl", 32'(ctl), 32'(E_RST));
    cyc();
    rst_n = 1'b1; mem_req = 1'b0; #1;
    chk("err_rst_state", 32'(dut.state_q), 32'(RUN));
    chk("err_rst_err", 32'(mem_err), 32'd0);
    chk("err_rst_stall", stall_cycles, 32'd0);
    chk("err_rst_ctl2", 32'(ctl), 32'(E_NORM));

    mem_req = 1'b1; #1;
    cyc(); cyc();
    chk("mw_state", 32'(dut.state_q), 32'(MEM_WAIT));
    chk("mw_stall", stall_cycles, 32'd2);
    rst_n = 1'b0; #1;
    chk("mw_rst_ctl", 32'(ctl), 32'(E_RST));
    cyc();
    chk("mw_rst_state", 32'(dut.state_q), 32'(RUN));
    chk("mw_rst_wait", 32'(dut.wait_q), 32'd0);
    chk("mw_rst_stall", stall_cycles, 32'd0);
    rst_n = 1'b1; mem_req = 1'b0; #1;
    chk("final_ctl", 32'(ctl), 32'(E_NORM));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
